// File: rtl/mdu_issue_ctrl.sv
// Issue controller between the pipeline and a multi-cycle multiply/divide unit.
// Handles RISC-V divide corner cases locally and holds the MDU operands stable while it computes.
module mdu_issue_ctrl #(
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [4:0]  req_rd,
   output logic [31:0] mdu_num1,
   output logic [31:0] mdu_num2,
   output logic [7:0]  mdu_mode,
   input  logic [31:0] mdu_ans,
   input  logic [1:0]  mdu_error,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_rd,
   output logic        rsp_exc,
   output logic        busy
);

   localparam logic [7:0] OP_DIV  = 8'h44;
   localparam logic [7:0] OP_DIVU = 8'h45;
   localparam logic [7:0] OP_REM  = 8'h46;
   localparam logic [7:0] OP_REMU = 8'h47;
   localparam logic [3:0] LAT4    = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state, next_state;
   logic [7:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [3:0]  cnt;
   logic [1:0]  err_q;
   logic        ready_en;
   logic        accept, capture;
   logic        is_div, is_rem, b_zero, overflow, special;
   logic [31:0] special_data;

   // Divide-by-zero and signed overflow have fixed architectural answers, so they never reach the MDU.
   always_comb begin
      is_div       = (req_op == OP_DIV) || (req_op == OP_DIVU);
      is_rem       = (req_op == OP_REM) || (req_op == OP_REMU);
      b_zero       = (req_b == 32'h0);
      overflow     = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                     (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
      special      = ((is_div || is_rem) && b_zero) || overflow;
      special_data = 32'h0;
      if (b_zero)
         special_data = is_div ? 32'hFFFF_FFFF : req_a;
      else if (req_op == OP_DIV)
         special_data = 32'h8000_0000;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Flush overrides every transition, including accept and retire.
   always_comb begin
      next_state = state;
      req_ready  = (state == IDLE) && ready_en;
      accept     = req_valid && req_ready && !flush;
      capture    = 1'b0;
      busy       = (state != IDLE);
      rsp_valid  = (state == RESP);
      mdu_mode   = 8'h00;
      mdu_num1   = 32'h0;
      mdu_num2   = 32'h0;
      case (state)
         IDLE: begin
            if (accept)
               next_state = special ? RESP : BUSY;
         end
         BUSY: begin
            mdu_mode = op_q;
            mdu_num1 = a_q;
            mdu_num2 = b_q;
            if (cnt == 4'd0) begin
               capture    = !flush;
               next_state = RESP;
            end
         end
         RESP: begin
            if (rsp_ready)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (flush)
         next_state = IDLE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         ready_en <= 1'b0;
      else
         ready_en <= 1'b1;
   end

   // Datapath: operand latch, latency counter and result capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_q     <= 8'h00;
         a_q      <= 32'h0;
         b_q      <= 32'h0;
         rsp_rd   <= 5'h0;
         cnt      <= 4'd0;
         rsp_data <= 32'h0;
         err_q    <= 2'b00;
      end else if (flush) begin
         cnt <= 4'd0;
      end else if (accept) begin
         op_q   <= req_op;
         a_q    <= req_a;
         b_q    <= req_b;
         rsp_rd <= req_rd;
         cnt    <= LAT4;
         if (special) begin
            rsp_data <= special_data;
            err_q    <= 2'b00;
         end
      end else if (state == BUSY) begin
         if (capture) begin
            rsp_data <= (mdu_error == 2'b11) ? 32'h0 : mdu_ans;
            err_q    <= mdu_error;
         end else begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   assign rsp_exc = (err_q == 2'b11);

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Randomised self-checking bench for mdu_issue_ctrl with a behavioural MDU and a reference result model.
module tb_mdu_issue_ctrl;
   localparam int LAT = 1;

   logic        clk, rstn, flush, req_valid, req_ready, rsp_valid, rsp_ready, rsp_exc, busy;
   logic [7:0]  req_op, mdu_mode;
   logic [31:0] req_a, req_b, mdu_num1, mdu_num2, mdu_ans, rsp_data;
   logic [4:0]  req_rd, rsp_rd;
   logic [1:0]  mdu_error;
   logic        force_err;
   int          errors = 0;
   int          checks = 0;

   mdu_issue_ctrl #(.LATENCY(LAT)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
      .mdu_num1(mdu_num1), .mdu_num2(mdu_num2), .mdu_mode(mdu_mode),
      .mdu_ans(mdu_ans), .mdu_error(mdu_error),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_rd(rsp_rd), .rsp_exc(rsp_exc), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] arith(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'h0;
      case (op)
         8'h40: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
         8'h41: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
         8'h42: begin p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b}); return p[63:32]; end
         8'h43: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
         8'h44: return $signed(a) / $signed(b);
         8'h45: return a / b;
         8'h46: return $signed(a) % $signed(b);
         8'h47: return a % b;
         default: return 32'h0;
      endcase
   endfunction

   // Behavioural MDU: one-edge delay; deliberately wrong answers for cases the controller must bypass.
   always @(posedge clk) begin
      if (mdu_mode < 8'h40 || mdu_mode > 8'h47 || force_err) begin
         mdu_ans   <= 32'h0BAD_0BAD;
         mdu_error <= 2'b11;
      end else if (mdu_mode >= 8'h44 && mdu_num2 == 32'h0) begin
         mdu_ans   <= 32'h0DEA_D0DE;
         mdu_error <= 2'b01;
      end else if ((mdu_mode == 8'h44 || mdu_mode == 8'h46) &&
                   mdu_num1 == 32'h8000_0000 && mdu_num2 == 32'hFFFF_FFFF) begin
         mdu_ans   <= 32'h1234_5678;
         mdu_error <= 2'b00;
      end else begin
         mdu_ans   <= arith(mdu_mode, mdu_num1, mdu_num2);
         mdu_error <= 2'b00;
      end
   end

   task automatic ref_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit ferr, output logic [31:0] data, output logic exc, output bit special);
      bit is_div, is_rem;
      is_div  = (op == 8'h44) || (op == 8'h45);
      is_rem  = (op == 8'h46) || (op == 8'h47);
      special = 1'b1;
      exc     = 1'b0;
      if ((is_div || is_rem) && b == 0)
         data = is_div ? 32'hFFFF_FFFF : a;
      else if (op == 8'h44 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         data = 32'h8000_0000;
      else if (op == 8'h46 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         data = 32'h0;
      else begin
         special = 1'b0;
         if (op < 8'h40 || op > 8'h47 || ferr) begin
            data = 32'h0;
            exc  = 1'b1;
         end else
            data = arith(op, a, b);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd);
      int w;
      @(negedge clk);
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("[TB] FAIL ready_wait: req_ready=%b required 1", req_ready);
      end
      req_valid = 1'b1;
      req_op = op;
      req_a = a;
      req_b = b;
      req_rd = rd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op = 8'($urandom);
      req_a = $urandom;
      req_b = $urandom;
      req_rd = 5'($urandom);
   endtask

   task automatic run_txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit ferr, input int stall, input string name);
      logic [31:0] exp_data;
      logic        exp_exc;
      bit          special;
      int          k, exp_k;
      ref_model(op, a, b, ferr, exp_data, exp_exc, special);
      exp_k = special ? 0 : LAT + 1;
      force_err = ferr;
      rsp_ready = 1'b0;
      applyStimulus(op, a, b, rd);
      @(negedge clk);
      checks++;
      if (mdu_mode !== (special ? 8'h00 : op)) begin
         errors++;
         $display("[TB] FAIL %s mdu_mode: got %h required %h", name, mdu_mode, special ? 8'h00 : op);
      end
      k = 0;
      while (!rsp_valid && k < 40) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (!rsp_valid && mdu_mode !== (special ? 8'h00 : op)) begin
            errors++;
            $display("[TB] FAIL %s mdu_mode_hold: got %h", name, mdu_mode);
         end
      end
      checks++;
      if (k !== exp_k || !rsp_valid) begin
         errors++;
         $display("[TB] FAIL %s latency: got %0d edges valid=%b required %0d", name, k, rsp_valid, exp_k);
      end
      checks++;
      if (rsp_data !== exp_data) begin
         errors++;
         $display("[TB] FAIL %s rsp_data: got %h required %h", name, rsp_data, exp_data);
      end
      checks++;
      if (rsp_exc !== exp_exc || rsp_rd !== rd) begin
         errors++;
         $display("[TB] FAIL %s rsp_exc/rd: got %b/%0d required %b/%0d", name, rsp_exc, rsp_rd, exp_exc, rd);
      end
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_rd !== rd || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s hold: valid=%b data=%h rd=%0d ready=%b required 1/%h/%0d/0",
                     name, rsp_valid, rsp_data, rsp_rd, req_ready, exp_data, rd);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      force_err = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s retire: valid=%b ready=%b busy=%b required 0/1/0", name, rsp_valid, req_ready, busy);
      end
   endtask

   task automatic checkOutput(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("[TB] FAIL %s no_rsp: rsp_valid seen %0d cycles required 0", name, seen);
      end
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      #12;
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || mdu_mode !== 8'h00 ||
          mdu_num1 !== 32'h0 || mdu_num2 !== 32'h0 || rsp_data !== 32'h0 || rsp_rd !== 5'h0 || rsp_exc !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: ready=%b busy=%b valid=%b mode=%h data=%h rd=%0d exc=%b required all 0",
                  req_ready, busy, rsp_valid, mdu_mode, rsp_data, rsp_rd, rsp_exc);
      end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ready_before_edge: got %b required 0", req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ready_after_edge: got %b required 1", req_ready);
      end
   endtask

   task automatic test_mul;
      run_txn(8'h40, 32'd7, 32'd6, 5'd5, 1'b0, 0, "mul_7x6");
   endtask

   task automatic test_special;
      run_txn(8'h45, 32'd100, 32'd0, 5'd1, 1'b0, 0, "divu_by0");
      run_txn(8'h46, 32'hFFFF_FFFB, 32'd0, 5'd2, 1'b0, 0, "rem_by0");
      run_txn(8'h44, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b0, 0, "div_ovf");
      run_txn(8'h46, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b0, 0, "rem_ovf");
   endtask

   task automatic test_mode_error;
      run_txn(8'h43, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 1'b1, 0, "mulhu_err");
   endtask

   task automatic test_backpressure;
      run_txn(8'h41, 32'hFFFF_FFF0, 32'd3, 5'd9, 1'b0, 5, "backpressure");
   endtask

   task automatic test_flush;
      // Flush on the same edge as a valid request must block the accept.
      @(negedge clk);
      req_valid = 1'b1; req_op = 8'h40; req_a = 32'd2; req_b = 32'd2; req_rd = 5'd6;
      flush = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_vs_accept: busy=%b ready=%b required 0/1", busy, req_ready);
      end
      applyStimulus(8'h40, 32'd11, 32'd13, 5'd7);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_busy: busy=%b valid=%b required 0/0", busy, rsp_valid);
      end
      checkOutput("flush", 6);
      run_txn(8'h40, 32'd3, 32'd3, 5'd8, 1'b0, 0, "mul_after_flush");
   endtask

   task automatic test_reset_mid;
      applyStimulus(8'h42, 32'hDEAD_BEEF, 32'd77, 5'd12);
      @(negedge clk);
      rstn = 1'b0;
      #2;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || mdu_mode !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_mid: busy=%b valid=%b mode=%h required 0/0/00", busy, rsp_valid, mdu_mode);
      end
      @(negedge clk);
      rstn = 1'b1;
      checkOutput("reset_mid", 6);
      run_txn(8'h40, 32'd3, 32'd3, 5'd13, 1'b0, 0, "mul_after_reset");
   endtask

   task automatic test_random;
      logic [7:0]  op;
      logic [31:0] a, b;
      int          sel;
      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 15));
         op  = (sel == 0) ? 8'h30 : (sel == 1) ? 8'h48 : 8'h40 + 8'($urandom_range(0, 7));
         a   = $urandom;
         b   = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 9) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         run_txn(op, a, b, 5'($urandom), $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), "random");
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      flush = 1'b0; req_valid = 1'b0; req_op = 8'h00; req_a = 32'h0; req_b = 32'h0;
      req_rd = 5'h0; rsp_ready = 1'b0; force_err = 1'b0;
      test_reset;
      test_mul;
      test_special;
      test_mode_error;
      test_backpressure;
      test_flush;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mdu_issue_ctrl.md
MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

Interface
REQ-001 Parameter: LATENCY, default 1, number of clk edges the MDU needs from stable operands/mode to valid ans; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous abort of any in-flight operation.
REQ-005 req_valid  input  1  pipeline presents an M-extension op.
REQ-006 req_ready  output  1  controller can accept; high only in IDLE.
REQ-007 req_op  input  8  mode code, 8'h40..8'h47 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-008 req_a, req_b  input  32 each  rs1 and rs2 operands.
REQ-009 req_rd  input  5  destination register tag.
REQ-010 mdu_num1, mdu_num2  output  32 each  operands driven to the MDU.
REQ-011 mdu_mode  output  8  mode driven to the MDU.
REQ-012 mdu_ans  input  32  MDU result.
REQ-013 mdu_error  input  2  MDU error: 00 none, 01 divide-by-zero, 11 mode error.
REQ-014 rsp_valid  output  1  result available.
REQ-015 rsp_ready  input  1  writeback accepts result.
REQ-016 rsp_data  output  32  result value.
REQ-017 rsp_rd  output  5  tag of the result.
REQ-018 rsp_exc  output  1  illegal-mode exception flag for this result.
REQ-019 busy  output  1  high whenever state is not IDLE; drives pipeline stall.

Function
REQ-020 FSM states: IDLE, BUSY, RESP; the transaction is accepted on an edge where req_valid and req_ready are both high.
REQ-021 On accept: latch op, a, b and rd; the latched values drive mdu_num1/mdu_num2/mdu_mode and stay stable for the whole BUSY period; in IDLE/RESP mdu_mode = 8'h00 and mdu_num1/mdu_num2 = 0.
REQ-022 Special cases bypass the MDU and go IDLE->RESP on the accept edge; the response is visible in the next cycle:
- DIV/DIVU with b=0 -> 32'hFFFFFFFF
- REM/REMU with b=0 -> a
- DIV with a=32'h80000000, b=32'hFFFFFFFF -> 32'h80000000
- REM with the same operands -> 0
REQ-023 Otherwise, on the accept edge: IDLE->BUSY and a 4-bit counter is loaded with LATENCY.
REQ-024 While in BUSY: the counter decrements on each edge; on the edge where the counter is 0, capture mdu_ans into rsp_data and mdu_error into an error register, then go to RESP. Total latency is accept edge + LATENCY+1 edges.
REQ-025 If the captured mdu_error = 2'b11, then rsp_data = 0 and rsp_exc = 1; otherwise rsp_exc = 0. Captured 2'b01 cannot occur because of REQ-022 and is ignored.
REQ-026 In RESP: rsp_valid = 1, and rsp_data, rsp_rd and rsp_exc are held stable until the edge where rsp_ready = 1; on that edge go to IDLE.
REQ-027 No new request is accepted in the cycle the response retires, because req_ready is low in RESP.
REQ-028 rsp_valid is 0 in IDLE and BUSY.
REQ-029 flush = 1 on an edge forces IDLE from any state, discards the pending result, clears rsp_valid, and prevents any accept on that edge; flush has priority over accept and over retire.
REQ-030 The result is independent of req_* changes after accept.

Reset
REQ-031 rstn low asynchronously forces IDLE, counter = 0, rsp_valid = 0, rsp_data = 0, rsp_rd = 0, rsp_exc = 0, mdu_mode = 0, mdu_num1/mdu_num2 = 0, busy = 0; req_ready rises on the first edge after rstn deasserts.
REQ-032 Reset mid-BUSY or mid-RESP drops the operation without emitting a response.

Verification
REQ-033 LATENCY=1, bench MDU model with 1-edge delay; MUL a=7, b=6, rsp_ready=1 -> rsp_valid high 2 cycles after accept, rsp_data = 42, rsp_exc = 0, then req_ready = 1.
REQ-034 DIVU a=100, b=0 -> rsp_data = 32'hFFFFFFFF one cycle after accept, and mdu_mode stays 8'h00 throughout; REM a=-5, b=0 -> rsp_data = 32'hFFFFFFFB.
REQ-035 DIV a=32'h80000000, b=32'hFFFFFFFF -> rsp_data = 32'h80000000; REM with the same operands -> 0; both one cycle after accept.
REQ-036 MULHU with the model returning mdu_error = 11 -> rsp_data = 0, rsp_exc = 1, rsp_rd = request tag.
REQ-037 Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid/rsp_data/rsp_rd stable and req_ready = 0; retire on the 6th cycle.
REQ-038 flush pulsed, and separately rstn pulsed low, in the first BUSY cycle -> no rsp_valid is ever raised for that op, busy = 0 next cycle, and the next MUL 3*3 returns 9.
